// File: rtl/pattern_player_pkg.sv
// -----------------------------------------------------------------------------
// pattern_player_pkg
//   Shared definitions for the pattern player and its neighbours (MMIO decode,
//   LED flasher, audio unit): color codes, FSM state encoding and the flash
//   command bundle that travels with each strobe.
// -----------------------------------------------------------------------------
package pattern_player_pkg;

    localparam int COLOR_W = 2;

    typedef enum logic [COLOR_W-1:0] {
        COLOR_RED    = 2'b00,
        COLOR_BLUE   = 2'b01,
        COLOR_GREEN  = 2'b10,
        COLOR_YELLOW = 2'b11
    } color_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ON   = 2'b10,
        ST_GAP  = 2'b11
    } state_e;

    // Everything the LED and audio units see on a strobe.
    typedef struct packed {
        logic   strobe;
        logic   on_off;
        color_e color;
    } flash_cmd_t;

endpackage : pattern_player_pkg

// File: rtl/pattern_player_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with a registered occupancy count. The head entry is
//   visible combinationally on rd_data so a pop and its data share one cycle.
//
//   Ports
//     clock    : rising-edge clock
//     reset    : synchronous, active-low
//     flush    : empty the FIFO at the next edge (beats wr_en and rd_en)
//     wr_en    : push wr_data; accepted when not full, or when full with a
//                concurrent pop
//     wr_data  : WIDTH-bit entry to push
//     rd_en    : pop the head entry (ignored when empty)
//     rd_data  : current head entry
//     full     : count == DEPTH
//     empty    : count == 0
//     count    : entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    assign rd_ok = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push at full still fits.
    assign wr_ok = wr_en && (!full || rd_ok);

    // NOTE: storage is deliberately not reset; pointers and count define
    // which entries are valid, and a resettable array costs a mux per bit.
    always_ff @(posedge clock) begin
        if (reset && !flush && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH (a power of two) wraps them.
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/pattern_player.sv
// -----------------------------------------------------------------------------
// pattern_player
//   Plays back a queue of color codes as timed on/off flashes. Each entry is
//   popped (LOAD), announced with an "on" strobe, held for on_len cycles,
//   announced with an "off" strobe, then followed by gap_len quiet cycles.
//   When the queue runs dry at the end of a gap, done pulses once.
//
//   Ports
//     clock, reset      : rising-edge clock, synchronous active-low reset
//     wr_en, wr_color   : push a color code into the FIFO
//     start             : begin playback (only from IDLE with data queued)
//     abort             : stop at the next edge and flush; an interrupted
//                         on phase gets a closing off strobe
//     on_len, gap_len   : phase lengths in cycles, latched at start (0 -> 1)
//     strobe            : one-cycle command pulse to LED / audio units
//     color, on_off     : command payload, held between strobes
//     busy              : not IDLE
//     full, empty, count: FIFO status
//     done              : one-cycle pulse when playback ends normally
// -----------------------------------------------------------------------------
module pattern_player
    import pattern_player_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 26
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [COLOR_W-1:0]     wr_color,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CNT_W-1:0]       on_len,
    input  logic [CNT_W-1:0]       gap_len,
    output logic                   strobe,
    output logic [COLOR_W-1:0]     color,
    output logic                   on_off,
    output logic                   busy,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   done
);

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   timer_q,   timer_d;
    logic [CNT_W-1:0]   on_len_q,  on_len_d;
    logic [CNT_W-1:0]   gap_len_q, gap_len_d;
    flash_cmd_t         flash_q,   flash_d;
    logic               done_q,    done_d;

    logic               fifo_wr;
    logic               fifo_rd;
    logic               fifo_flush;
    logic [COLOR_W-1:0] fifo_head;

    // A zero length would otherwise underflow the down-counter.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    // abort wins over a same-cycle write.
    assign fifo_wr = wr_en && !abort;

    sync_fifo #(
        .DEPTH   (DEPTH),
        .WIDTH   (COLOR_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data (wr_color),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            on_len_q  <= '0;
            gap_len_q <= '0;
            flash_q   <= '{strobe: 1'b0, on_off: 1'b0, color: COLOR_RED};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            on_len_q  <= on_len_d;
            gap_len_q <= gap_len_d;
            flash_q   <= flash_d;
            done_q    <= done_d;
        end
    end

    // The timer holds the cycles left in the current phase, counting the
    // present one; the phase ends in the cycle where it reads 1.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d        = state_q;
        timer_d        = timer_q;
        on_len_d       = on_len_q;
        gap_len_d      = gap_len_q;
        flash_d        = flash_q;
        flash_d.strobe = 1'b0;
        done_d         = 1'b0;
        fifo_rd        = 1'b0;
        fifo_flush     = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            timer_d    = '0;
            fifo_flush = 1'b1;
            // Close an interrupted on phase so nothing stays lit or sounding.
            if (state_q == ST_ON) begin
                flash_d.strobe = 1'b1;
                flash_d.on_off = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !empty) begin
                        state_d   = ST_LOAD;
                        on_len_d  = at_least_one(on_len);
                        gap_len_d = at_least_one(gap_len);
                    end
                end

                ST_LOAD: begin
                    // Registered strobe lands in the first ON cycle.
                    fifo_rd        = 1'b1;
                    flash_d.color  = color_e'(fifo_head);
                    flash_d.strobe = 1'b1;
                    flash_d.on_off = 1'b1;
                    timer_d        = on_len_q;
                    state_d        = ST_ON;
                end

                ST_ON: begin
                    if (timer_q <= CNT_W'(1)) begin
                        flash_d.strobe = 1'b1;
                        flash_d.on_off = 1'b0;
                        timer_d        = gap_len_q;
                        state_d        = ST_GAP;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    if (timer_q <= CNT_W'(1)) begin
                        timer_d = '0;
                        if (empty) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign strobe = flash_q.strobe;
    assign on_off = flash_q.on_off;
    assign color  = flash_q.color;
    assign done   = done_q;
    assign busy   = (state_q != ST_IDLE);

endmodule : pattern_player

// File: tb/tb_pattern_player.sv
// -----------------------------------------------------------------------------
// tb_pattern_player
//   Drives pattern_player with directed scenarios and a randomized phase.
//   The reference model tracks the FIFO as a queue and playback as absolute
//   cycle numbers for each element's load, on start, off strobe and gap end.
// -----------------------------------------------------------------------------
module tb_pattern_player;

    localparam int DEPTH = 16;
    localparam int CNT_W = 26;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic             clock;
    logic             reset;
    logic             wr_en;
    logic [1:0]       wr_color;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] on_len;
    logic [CNT_W-1:0] gap_len;
    logic             strobe;
    logic [1:0]       color;
    logic             on_off;
    logic             busy;
    logic             full;
    logic             empty;
    logic [CNTW-1:0]  count;
    logic             done;

    pattern_player #(
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_color (wr_color),
        .start    (start),
        .abort    (abort),
        .on_len   (on_len),
        .gap_len  (gap_len),
        .strobe   (strobe),
        .color    (color),
        .on_off   (on_off),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int   q[$];
    bit   model_valid = 0;
    bit   playing     = 0;
    int   load_c, on_start, off_c, gend_c;
    int   on_l, gap_l;
    bit   exp_strobe, exp_on_off, exp_done;
    int   exp_color;

    // Predicts the outputs of cycle cyc+1 from the inputs applied in cycle cyc.
    task automatic model_update(input bit rst_v, input bit wr_v, input int col_v,
                                input bit st_v, input bit ab_v, input int on_v, input int gap_v);
        int  n;
        int  pre_size;
        bit  pop_now;
        n = cyc;
        if (!rst_v) begin
            q.delete();
            playing    = 0;
            exp_strobe = 0;
            exp_on_off = 0;
            exp_done   = 0;
            exp_color  = 0;
            return;
        end
        exp_strobe = 0;
        exp_done   = 0;
        if (ab_v) begin
            if (playing && n >= on_start && n < off_c) begin
                exp_strobe = 1;
                exp_on_off = 0;
            end
            q.delete();
            playing = 0;
            return;
        end
        pre_size = q.size();
        pop_now  = playing && (n == load_c);
        if (playing && n == gend_c) begin
            if (pre_size == 0) begin
                exp_done = 1;
                playing  = 0;
            end else begin
                load_c = n + 1;
            end
        end
        if (playing && n + 1 == off_c) begin
            exp_strobe = 1;
            exp_on_off = 0;
        end
        if (pop_now) begin
            exp_color  = q.pop_front();
            exp_strobe = 1;
            exp_on_off = 1;
            on_start   = n + 1;
            off_c      = on_start + on_l;
            gend_c     = off_c + gap_l - 1;
        end
        if (wr_v && (pre_size < DEPTH || pop_now)) q.push_back(col_v);
        if (st_v && !playing && pre_size != 0) begin
            playing  = 1;
            load_c   = n + 1;
            on_l     = (on_v == 0) ? 1 : on_v;
            gap_l    = (gap_v == 0) ? 1 : gap_v;
            on_start = 0;
            off_c    = 0;
            gend_c   = 0;
        end
    endtask

    // ---------------- event log (observed) ----------------
    int ev_cyc[$];
    int ev_col[$];
    int ev_on[$];
    int done_cyc[$];

    task automatic clear_log();
        ev_cyc.delete();
        ev_col.delete();
        ev_on.delete();
        done_cyc.delete();
    endtask

    // Entered at a falling edge: compare, log, drive, predict, advance one cycle.
    task automatic step(input bit rst_v, input bit wr_v, input int col_v,
                        input bit st_v, input bit ab_v, input int on_v, input int gap_v);
        if (model_valid) begin
            check("strobe", 32'(strobe), 32'(exp_strobe));
            check("color",  32'(color),  32'(exp_color));
            check("on_off", 32'(on_off), 32'(exp_on_off));
            check("done",   32'(done),   32'(exp_done));
            check("busy",   32'(busy),   32'(playing));
            check("count",  32'(count),  32'(q.size()));
            check("empty",  32'(empty),  32'(q.size() == 0));
            check("full",   32'(full),   32'(q.size() == DEPTH));
        end
        if (strobe === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_col.push_back(int'(color));
            ev_on.push_back(int'(on_off));
        end
        if (done === 1'b1) done_cyc.push_back(cyc);

        reset    = rst_v;
        wr_en    = wr_v;
        wr_color = col_v[1:0];
        start    = st_v;
        abort    = ab_v;
        on_len   = CNT_W'(on_v);
        gap_len  = CNT_W'(gap_v);
        model_update(rst_v, wr_v, col_v, st_v, ab_v, on_v, gap_v);
        if (!rst_v) model_valid = 1;
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic nop(input int n);
        repeat (n) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input int col_v);
        step(1, 1, col_v, 0, 0, 0, 0);
    endtask

    task automatic go(input int on_v, input int gap_v);
        step(1, 0, 0, 1, 0, on_v, gap_v);
    endtask

    initial begin
        int c0;
        int on_cyc[$];
        int on_col[$];

        reset = 1'b0; wr_en = 1'b0; wr_color = 2'b00; start = 1'b0;
        abort = 1'b0; on_len = '0; gap_len = '0;
        @(negedge clock);

        // Reset, with start/write/abort asserted to show reset wins.
        step(0, 1, 3, 1, 1, 3, 3);
        step(0, 0, 0, 0, 0, 0, 0);
        nop(2);

        // Single color.
        clear_log();
        push(1);
        c0 = cyc;
        go(4, 2);
        nop(8);
        check("s1_busy_c9", 32'(busy), 32'd0);
        check("s1_nstrobe", 32'(ev_cyc.size()), 32'd2);
        check("s1_on_cyc",  32'(ev_cyc[0] - c0), 32'd2);
        check("s1_on_col",  32'(ev_col[0]), 32'd1);
        check("s1_on_flag", 32'(ev_on[0]), 32'd1);
        check("s1_off_cyc", 32'(ev_cyc[1] - c0), 32'd6);
        check("s1_off_flag",32'(ev_on[1]), 32'd0);
        check("s1_ndone",   32'(done_cyc.size()), 32'd1);
        check("s1_done_cyc",32'(done_cyc[0] - c0), 32'd8);
        nop(2);

        // Sequence of three.
        clear_log();
        push(0); push(3); push(2);
        c0 = cyc;
        go(3, 1);
        nop(20);
        foreach (ev_cyc[i]) begin
            if (ev_on[i] == 1) begin
                on_cyc.push_back(ev_cyc[i] - c0);
                on_col.push_back(ev_col[i]);
            end
        end
        check("s2_n_on", 32'(on_cyc.size()), 32'd3);
        check("s2_on0",  32'(on_cyc[0]), 32'd2);
        check("s2_on1",  32'(on_cyc[1]), 32'd7);
        check("s2_on2",  32'(on_cyc[2]), 32'd12);
        check("s2_col0", 32'(on_col[0]), 32'd0);
        check("s2_col1", 32'(on_col[1]), 32'd3);
        check("s2_col2", 32'(on_col[2]), 32'd2);
        check("s2_ndone",32'(done_cyc.size()), 32'd1);

        // FIFO boundary: 17 writes, then a push during the LOAD pop at full.
        for (int i = 0; i < 17; i++) push(i % 4);
        check("s3_full",  32'(full),  32'd1);
        check("s3_count", 32'(count), 32'd16);
        c0 = cyc;
        go(2, 1);
        step(1, 1, 3, 0, 0, 0, 0);
        check("s3_load_push_count", 32'(count), 32'd16);
        check("s3_load_push_full",  32'(full),  32'd1);
        nop(3);
        step(1, 0, 0, 0, 1, 0, 0);
        check("s3_flush_empty", 32'(empty), 32'd1);
        nop(2);

        // Abort during the on phase of the second element.
        clear_log();
        push(0); push(1); push(2);
        c0 = cyc;
        go(5, 2);
        nop(10);
        step(1, 1, 3, 1, 1, 2, 2);
        nop(3);
        check("s4_last_cyc",  32'(ev_cyc[$] - c0), 32'd12);
        check("s4_last_off",  32'(ev_on[$]), 32'd0);
        check("s4_last_col",  32'(ev_col[$]), 32'd1);
        check("s4_ndone",     32'(done_cyc.size()), 32'd0);
        check("s4_empty",     32'(empty), 32'd1);
        check("s4_busy",      32'(busy), 32'd0);

        // Zero lengths, then a start with nothing queued.
        clear_log();
        push(2);
        c0 = cyc;
        go(0, 0);
        nop(5);
        check("s5_on_cyc",   32'(ev_cyc[0] - c0), 32'd2);
        check("s5_off_cyc",  32'(ev_cyc[1] - c0), 32'd3);
        check("s5_done_cyc", 32'(done_cyc[0] - c0), 32'd4);
        go(3, 3);
        check("s5_empty_start_busy", 32'(busy), 32'd0);
        nop(2);

        // Reset in the middle of a gap.
        clear_log();
        push(1); push(2);
        c0 = cyc;
        go(2, 4);
        nop(4);
        step(0, 0, 0, 0, 0, 0, 0);
        check("s6_strobe", 32'(strobe), 32'd0);
        check("s6_busy",   32'(busy),   32'd0);
        check("s6_color",  32'(color),  32'd0);
        check("s6_on_off", 32'(on_off), 32'd0);
        check("s6_count",  32'(count),  32'd0);
        nop(4);
        check("s6_nstrobe", 32'(ev_cyc.size()), 32'd2);
        check("s6_ndone",   32'(done_cyc.size()), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_wr, r_st, r_ab;
            r_rst = ($urandom_range(0, 999) >= 3);
            r_wr  = ($urandom_range(0, 99) < 35);
            r_st  = ($urandom_range(0, 99) < 8);
            r_ab  = ($urandom_range(0, 199) < 1);
            step(r_rst, r_wr, int'($urandom_range(0, 3)), r_st, r_ab,
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end
        nop(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pattern_player

// File: doc/pattern_player.md
PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning color FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter CNT_W, default 26, meaning width of on/gap timers (26 bits covers about 1.34 s at 50 MHz).
REQ-003 SHALL have port clock, input, 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port wr_en, input, 1: push wr_color into the FIFO this cycle.
REQ-006 SHALL have port wr_color, input, 2: color code (00 red, 01 blue, 10 green, 11 yellow).
REQ-007 SHALL have port start, input, 1: begin playback of FIFO contents.
REQ-008 SHALL have port abort, input, 1: stop playback and flush the FIFO.
REQ-009 SHALL have port on_len, input, CNT_W: on-phase length in cycles, sampled at start.
REQ-010 SHALL have port gap_len, input, CNT_W: gap length in cycles, sampled at start.
REQ-011 SHALL have port strobe, output, 1: one-cycle pulse to the LED flasher and audio units.
REQ-012 SHALL have port color, output, 2: color presented with strobe.
REQ-013 SHALL have port on_off, output, 1: 1 means turn on, 0 means turn off; valid with strobe.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port full, output, 1: FIFO full flag.
REQ-016 SHALL have port empty, output, 1: FIFO empty flag.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1: number of FIFO entries.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when playback completes normally.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, ON, GAP.
- IDLE -> LOAD: start=1 and empty=0.
- start while empty or busy: ignored.
REQ-020 On the IDLE->LOAD transition, SHALL latch on_len and gap_len; a latched value of 0 is treated as 1.
REQ-021 In LOAD (1 cycle), SHALL pop the FIFO head into the color register and go to ON.
REQ-022 SHALL assert strobe=1, on_off=1 with the latched color in the first ON cycle, so strobe occurs 2 cycles after the cycle in which start is accepted.
REQ-023 SHALL remain in ON for exactly on_len cycles, then go to GAP, asserting strobe=1, on_off=0 with the same color in the first GAP cycle.
REQ-024 SHALL remain in GAP for exactly gap_len cycles, then:
- FIFO not empty: go to LOAD.
- FIFO empty: pulse done for 1 cycle and go to IDLE.
REQ-025 SHALL hold strobe=0 in all other cycles; color and on_off SHALL hold their last values between strobes.
REQ-026 SHALL accept a write whenever full=0, in any state; a write while full SHALL be dropped with no state change.
REQ-027 On a simultaneous push and pop in LOAD, SHALL leave count unchanged; a push at full with a concurrent pop SHALL be accepted.
REQ-028 SHALL wrap FIFO pointers modulo DEPTH; count SHALL range 0..DEPTH.
REQ-029 On abort=1 (any state), SHALL go to IDLE at the next edge and flush the FIFO.
- If abort occurs in ON, SHALL emit strobe=1, on_off=0, color held, in that next cycle, so no LED or tone is left on.
- abort SHALL take priority over start and wr_en in the same cycle; done SHALL NOT pulse.
REQ-030 The timer SHALL count down; no arithmetic result may exceed CNT_W bits.

Reset
REQ-031 While reset=0 at a rising edge, the block SHALL be in IDLE with:
- FIFO pointers and count = 0, empty=1, full=0;
- strobe=0, done=0, busy=0, color=00, on_off=0;
- timers = 0.
REQ-032 Reset SHALL override abort, start and wr_en; reset mid-playback SHALL NOT emit an off strobe.

Structure
REQ-033 Color codes and FSM state encodings SHALL live in a shared package used by the MMIO decode and the LED and audio units.
REQ-034 The FIFO SHALL be a separate sub-module, sync_fifo (parameters DEPTH, WIDTH=2), exposing full, empty and count.

Verification
REQ-035 The bench SHALL cover the following scenarios:
- Single color: push 01, on_len=4, gap_len=2, start at cycle 0 -> strobe(01,on) at cycle 2, strobe(01,off) at cycle 6, done at cycle 8, busy low at cycle 9.
- Sequence: push 00,11,10 with on_len=3, gap_len=1 -> on-strobes at cycles 2,7,12 with colors 00,11,10 in order; done pulses exactly once.
- FIFO boundary: 17 writes at DEPTH=16 -> full=1, count=16, 17th write dropped; push during a LOAD pop at full -> count stays 16.
- Abort: abort during the ON of the 2nd element -> off-strobe the next cycle, then IDLE, empty=1, no done pulse.
- Zero length and ignored start: on_len=0 -> on phase lasts 1 cycle; start with an empty FIFO -> busy stays 0.
- Reset mid-GAP: reset=0 -> all outputs at reset values the next cycle, no strobe.
